crack_dispatch: RTL and testbench

Key-space dispatcher for the parallel ARC4 brute-force crack. It owns a pool of `NUM_CORES` single-key crack cores and hands each idle core the next untried key, ascending from 0 to `KEY_MAX`. It collects the per-core hit reports and stops issuing keys after the first hit. It drains in-flight cores and reports the smallest matching key through the top-level `en`/`rdy` handshake.

---
 rtl/crack_dispatch.sv | 173 +++++++++++++++++
 tb/tb_crack_dispatch.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crack_dispatch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : crack_dispatch
// Purpose  : Key-space dispatcher for a pool of single-key ARC4 crack cores.
//            Hands out ascending keys to idle cores, stops issuing on the
//            first hit, drains in-flight cores and reports the smallest hit.
// Revision : 1.0 - initial release
// ============================================================================
module crack_dispatch #(
  parameter int                   NUM_CORES = 2,
  parameter int                   KEY_WIDTH = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_MAX   = 24'hFFFFFF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  output logic                           rdy,
  output logic                           key_valid,
  output logic [KEY_WIDTH-1:0]           key,
  input  logic [NUM_CORES-1:0]           core_rdy,
  output logic [NUM_CORES-1:0]           core_en,
  output logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
  input  logic [NUM_CORES-1:0]           core_done,
  input  logic [NUM_CORES-1:0]           core_hit
);

  // One extra bit on the key counter so stepping past KEY_MAX never wraps.
  localparam logic [KEY_WIDTH:0] LAST_KEY = {1'b0, KEY_MAX};
  localparam logic [KEY_WIDTH:0] KEY_ONE  = {{KEY_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_DRAIN    = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic [KEY_WIDTH:0]             next_key_q, next_key_d;
  logic [NUM_CORES-1:0]           busy_q, busy_d;
  logic                           stop_q, stop_d;
  logic [KEY_WIDTH-1:0]           best_key_q, best_key_d;
  logic                           best_valid_q, best_valid_d;
  logic [KEY_WIDTH-1:0]           key_q, key_d;
  logic                           key_valid_q, key_valid_d;
  logic [NUM_CORES-1:0]           core_en_q, core_en_d;
  logic [NUM_CORES*KEY_WIDTH-1:0] core_key_q, core_key_d;

  logic [NUM_CORES-1:0]           grant;
  logic                           found;
  logic [NUM_CORES-1:0]           done_live;
  logic                           collect;
  logic                           may_dispatch;

  assign rdy       = (state_q == ST_IDLE);
  assign key_valid = key_valid_q;
  assign key       = key_q;
  assign core_en   = core_en_q;
  assign core_key  = core_key_q;

  // Next-state logic: pick the lowest idle core, merge hit reports, sequence the run.
  always_comb begin
    state_d      = state_q;
    next_key_d   = next_key_q;
    busy_d       = busy_q;
    stop_d       = stop_q;
    best_key_d   = best_key_q;
    best_valid_d = best_valid_q;
    key_d        = key_q;
    key_valid_d  = key_valid_q;
    core_en_d    = '0;
    core_key_d   = core_key_q;
    grant        = '0;
    found        = 1'b0;

    // Done pulses from cores we never started are stale and must not count.
    done_live    = core_done & busy_q;
    collect      = (state_q == ST_DISPATCH) || (state_q == ST_DRAIN);
    may_dispatch = (state_q == ST_DISPATCH) && !stop_q && (next_key_q <= LAST_KEY);

    for (int i = 0; i < NUM_CORES; i++) begin
      if (!found && core_rdy[i] && !busy_q[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end

    // Lower indices are merged first; strict less-than keeps the smallest key.
    if (collect) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (done_live[i]) begin
          busy_d[i] = 1'b0;
          if (core_hit[i]) begin
            stop_d = 1'b1;
            if (!best_valid_d || (core_key_q[i*KEY_WIDTH +: KEY_WIDTH] < best_key_d)) begin
              best_key_d   = core_key_q[i*KEY_WIDTH +: KEY_WIDTH];
              best_valid_d = 1'b1;
            end
          end
        end
      end
    end

    if (may_dispatch && found) begin
      core_en_d = grant;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (grant[i]) begin
          core_key_d[i*KEY_WIDTH +: KEY_WIDTH] = next_key_q[KEY_WIDTH-1:0];
        end
      end
      busy_d     = busy_d | grant;
      next_key_d = next_key_q + KEY_ONE;
    end

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d      = ST_DISPATCH;
          next_key_d   = '0;
          busy_d       = '0;
          stop_d       = 1'b0;
          best_key_d   = '0;
          best_valid_d = 1'b0;
          key_d        = '0;
          key_valid_d  = 1'b0;
        end
      end
      ST_DISPATCH: begin
        if (stop_q || (next_key_q > LAST_KEY)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // With nothing busy no done can be merged this cycle, so best_* is final.
        if (busy_q == '0) begin
          state_d     = ST_IDLE;
          key_d       = best_key_q;
          key_valid_d = best_valid_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      next_key_q   <= '0;
      busy_q       <= '0;
      stop_q       <= 1'b0;
      best_key_q   <= '0;
      best_valid_q <= 1'b0;
      key_q        <= '0;
      key_valid_q  <= 1'b0;
      core_en_q    <= '0;
      core_key_q   <= '0;
    end else begin
      state_q      <= state_d;
      next_key_q   <= next_key_d;
      busy_q       <= busy_d;
      stop_q       <= stop_d;
      best_key_q   <= best_key_d;
      best_valid_q <= best_valid_d;
      key_q        <= key_d;
      key_valid_q  <= key_valid_d;
      core_en_q    <= core_en_d;
      core_key_q   <= core_key_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_crack_dispatch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_crack_dispatch
// Purpose  : Self-checking bench for crack_dispatch: table of full runs against
//            behavioural cores, plus hand-driven reset and handshake sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_crack_dispatch;

  localparam int NC = 2;
  localparam int KW = 4;

  logic clk = 1'b0;
  logic rst_n;

  // Main instance: two cores, keys 0..15
  logic             en;
  logic             rdy, key_valid;
  logic [KW-1:0]    key;
  logic [NC-1:0]    core_rdy, core_en, core_done, core_hit;
  logic [NC*KW-1:0] core_key;

  // Handshake instance: one core, keys 0..1, cores driven by hand
  logic          h_en;
  logic          h_rdy, h_key_valid;
  logic [KW-1:0] h_key;
  logic [0:0]    h_core_rdy, h_core_en, h_core_done, h_core_hit;
  logic [KW-1:0] h_core_key;

  // Behavioural-core configuration: hit set and per-key latency (nibble per key)
  logic [15:0] hit_mask;
  logic [63:0] lat_tab;

  int checks = 0;
  int errors = 0;

  // Dispatch log
  int          disp_n = 0;
  int          disp_key  [128];
  int          disp_core [128];
  logic [KW-1:0] en_key;
  int          en_core;

  crack_dispatch #(.NUM_CORES(NC), .KEY_WIDTH(KW), .KEY_MAX(4'd15)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .key_valid(key_valid), .key(key),
    .core_rdy(core_rdy), .core_en(core_en), .core_key(core_key),
    .core_done(core_done), .core_hit(core_hit)
  );

  crack_dispatch #(.NUM_CORES(1), .KEY_WIDTH(KW), .KEY_MAX(4'd1)) u_hs (
    .clk(clk), .rst_n(rst_n), .en(h_en), .rdy(h_rdy), .key_valid(h_key_valid), .key(h_key),
    .core_rdy(h_core_rdy), .core_en(h_core_en), .core_key(h_core_key),
    .core_done(h_core_done), .core_hit(h_core_hit)
  );

  always #5 clk = ~clk;

  // Behavioural crack cores, acting on the falling edge so the DUT sees stable inputs
  generate
    for (genvar g = 0; g < NC; g++) begin : g_core
      logic          rdy_r, done_r, hit_r;
      logic [KW-1:0] lkey;
      logic [3:0]    cnt;
      always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdy_r <= 1'b1; done_r <= 1'b0; hit_r <= 1'b0; cnt <= 4'd0; lkey <= '0;
        end else begin
          done_r <= 1'b0;
          hit_r  <= 1'b0;
          if (core_en[g]) begin
            lkey  <= core_key[g*KW +: KW];
            cnt   <= lat_tab[{core_key[g*KW +: KW], 2'b00} +: 4];
            rdy_r <= 1'b0;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              done_r <= 1'b1;
              hit_r  <= hit_mask[lkey];
              rdy_r  <= 1'b1;
            end
          end
        end
      end
      assign core_rdy[g]  = rdy_r;
      assign core_done[g] = done_r;
      assign core_hit[g]  = hit_r;
    end
  endgenerate

  // Lowest core currently being started, for the log
  always_comb begin
    en_key  = '0;
    en_core = -1;
    for (int i = NC - 1; i >= 0; i--) begin
      if (core_en[i]) begin
        en_key  = core_key[i*KW +: KW];
        en_core = i;
      end
    end
  end

  // Record every dispatch in order
  always @(negedge clk) begin
    if (|core_en) begin
      if (disp_n < 128) begin
        disp_key[disp_n]  <= int'(en_key);
        disp_core[disp_n] <= en_core;
      end
      disp_n <= disp_n + $countones(core_en);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_rdy(input string name, input int budget);
    int n = 0;
    while (!rdy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(rdy), 1);
  endtask

  task automatic wait_h_core_en(input string name, input int exp_key);
    int n = 0;
    while (!h_core_en[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_en"}, int'(h_core_en[0]), 1);
    check({name, "_key"}, int'(h_core_key), exp_key);
  endtask

  task automatic wait_h_rdy(input string name);
    int n = 0;
    while (!h_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(h_rdy), 1);
  endtask

  typedef struct {
    string       name;
    logic [15:0] mask;
    logic [63:0] lat;
    int          exp_valid;
    int          exp_key;
    int          exp_n;
  } vec_t;

  vec_t vecs[4];

  task automatic run_vec(input int v);
    int  base;
    int  n;
    bit  ordered;
    base     = disp_n;
    hit_mask = vecs[v].mask;
    lat_tab  = vecs[v].lat;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    check({vecs[v].name, "_rdy_low"}, int'(rdy), 0);
    wait_rdy({vecs[v].name, "_rdy_rise"}, 600);
    @(negedge clk);
    n = disp_n - base;
    check({vecs[v].name, "_ndisp"}, n, vecs[v].exp_n);
    ordered = 1'b1;
    for (int j = 0; j < n && base + j < 128; j++) begin
      if (disp_key[base + j] != j) ordered = 1'b0;
    end
    check({vecs[v].name, "_order"}, int'(ordered), 1);
    check({vecs[v].name, "_key_valid"}, int'(key_valid), vecs[v].exp_valid);
    check({vecs[v].name, "_key"}, int'(key), vecs[v].exp_key);
    check({vecs[v].name, "_rdy"}, int'(rdy), 1);
    if (v == 2) begin
      check("ooo_key2_core", disp_core[base + 2], 0);
      check("ooo_key3_core", disp_core[base + 3], 1);
    end
  endtask

  task automatic reset_midrun();
    int n = 0;
    hit_mask = 16'h0040;
    lat_tab  = 64'h5555_5555_5555_5555;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    while (core_en == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_pre_core_en", int'(|core_en), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_rdy", int'(rdy), 1);
    check("rst_mid_core_en", int'(core_en), 0);
    check("rst_mid_key_valid", int'(key_valid), 0);
    check("rst_mid_core_key", int'(core_key), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    en          = 1'b0;
    hit_mask    = '0;
    lat_tab     = 64'h5555_5555_5555_5555;
    h_en        = 1'b0;
    h_core_rdy  = 1'b1;
    h_core_done = 1'b0;
    h_core_hit  = 1'b0;

    vecs[0] = '{name: "single_hit", mask: 16'h0040, lat: 64'h5555_5555_5555_5555,
                exp_valid: 1, exp_key: 6, exp_n: 8};
    vecs[1] = '{name: "no_hit", mask: 16'h0000, lat: 64'h5555_5555_5555_5555,
                exp_valid: 0, exp_key: 0, exp_n: 16};
    vecs[2] = '{name: "ooo_hit", mask: 16'h000C, lat: 64'h5555_5555_5555_3C53,
                exp_valid: 1, exp_key: 2, exp_n: 4};
    vecs[3] = '{name: "simul_hit", mask: 16'h0300, lat: 64'h5555_5556_3555_5555,
                exp_valid: 1, exp_key: 8, exp_n: 10};

    repeat (3) @(negedge clk);
    check("reset_rdy", int'(rdy), 1);
    check("reset_key_valid", int'(key_valid), 0);
    check("reset_key", int'(key), 0);
    check("reset_core_en", int'(core_en), 0);
    check("reset_core_key", int'(core_key), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      run_vec(v);
      if (v == 0) reset_midrun();
    end

    // Handshake: en held through run 1, stray done, back-to-back run 2
    h_en = 1'b1;
    wait_h_core_en("hs_r1_k0", 0);
    check("hs_rdy_low", int'(h_rdy), 0);
    @(negedge clk);
    h_core_done = 1'b1; h_core_hit = 1'b0;
    @(negedge clk);
    h_core_done = 1'b1; h_core_hit = 1'b1;   // stray: core not busy now
    @(negedge clk);
    h_core_done = 1'b0; h_core_hit = 1'b0;
    wait_h_core_en("hs_r1_k1", 1);
    @(negedge clk);
    h_core_done = 1'b1; h_core_hit = 1'b1;
    @(negedge clk);
    h_core_done = 1'b0; h_core_hit = 1'b0;
    wait_h_rdy("hs_r1_rdy");
    check("hs_r1_key_valid", int'(h_key_valid), 1);
    check("hs_r1_key", int'(h_key), 1);
    @(negedge clk);
    check("hs_r2_rdy_low", int'(h_rdy), 0);
    check("hs_r2_key_valid_clr", int'(h_key_valid), 0);
    check("hs_r2_key_clr", int'(h_key), 0);
    h_en = 1'b0;
    wait_h_core_en("hs_r2_k0", 0);
    h_core_done = 1'b1; h_core_hit = 1'b0;
    @(negedge clk);
    h_core_done = 1'b0;
    wait_h_core_en("hs_r2_k1", 1);
    h_core_done = 1'b1; h_core_hit = 1'b0;
    @(negedge clk);
    h_core_done = 1'b0;
    wait_h_rdy("hs_r2_rdy");
    check("hs_r2_key_valid", int'(h_key_valid), 0);
    check("hs_r2_key", int'(h_key), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
